controlador_irrigacao: RTL
==========================

# controlador_irrigacao

Irrigation mode controller sitting directly upstream of the countdown timer (`cronometro`): it generates the 1 s `umSegundo` clock from the board clock and decides, from synchronized soil/temperature/tank sensors, when to drive the `aspersao` or `gotejamento` mode lines that preset and release the timer. It also runs tank refill, times each phase in seconds, and raises an alarm on tank faults.

## Interface
- `MEIO_PERIODO`, 25_000_000: board-clock cycles per half period of `umSegundo`.
- `DURACAO_ASPERSAO`, 3060: sprinkler phase length, seconds.
- `DURACAO_GOTEJAMENTO`, 180: drip phase length, seconds.
- `TEMPO_ENCHER`, 600: refill timeout, seconds.
- `clock` in 1: board clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `habilita` in 1: system enable (async, synchronized internally).
- `soloSeco` in 1: soil-dry sensor (async).
- `temperaturaAlta` in 1: high-temperature sensor (async).
- `nivelBaixo` in 1: tank-low sensor (async).
- `nivelCheio` in 1: tank-full sensor (async).
- `umSegundo` out 1: 1 Hz square wave, 50% duty, for the timer.
- `aspersao` out 1: sprinkler mode.
- `gotejamento` out 1: drip mode.
- `valvulaEntrada` out 1: tank inlet valve.
- `alarme` out 1: fault indicator.
- `estado` out 3: current state code.

## Operation
- Reset (async, `reset`=0): every register cleared; all outputs 0, `estado`=0 (OCIOSO), prescaler and seconds counter 0.
- Each sensor input passes through a 2-flop synchronizer; the FSM uses only synchronized values.
- Prescaler: counts 0..MEIO_PERIODO-1; at terminal count, wraps to 0 and toggles `umSegundo`. Internal `tick` is a one-cycle pulse on the 0->1 toggle. The prescaler runs in every state, independent of the FSM.
- Seconds counter: 16 bits; cleared on every state change, increments on `tick`, saturates at 0xFFFF.
- States (`estado` code):
  - OCIOSO (0): all mode outputs 0.
  - ASPERSAO (1): `aspersao`=1.
  - GOTEJAMENTO (2): `gotejamento`=1.
  - ENCHENDO (3): `valvulaEntrada`=1.
  - ERRO (4): `alarme`=1.
- Transitions, evaluated in priority order:
  1. `habilita`=0 -> OCIOSO from any state. This also clears ERRO.
  2. `nivelBaixo`=1 and `nivelCheio`=1 together (inconsistent sensors) -> ERRO from any non-ERRO state.
  3. OCIOSO with `soloSeco`=1:
     - `nivelBaixo`=1 -> ENCHENDO;
     - else `temperaturaAlta`=1 -> GOTEJAMENTO;
     - else -> ASPERSAO.
  4. ASPERSAO or GOTEJAMENTO with `nivelBaixo`=1 -> ENCHENDO (phase aborted).
  5. ASPERSAO -> OCIOSO on the `tick` that brings the seconds counter to DURACAO_ASPERSAO. GOTEJAMENTO does the same with DURACAO_GOTEJAMENTO.
  6. ENCHENDO with `nivelCheio`=1 -> OCIOSO. A `tick` that brings the counter to TEMPO_ENCHER -> ERRO. If both occur in the same cycle, `nivelCheio` wins.
  7. ERRO is held until `habilita`=0 or reset.
- `aspersao` and `gotejamento` are never 1 together; at most one of `aspersao`, `gotejamento`, `valvulaEntrada`, `alarme` is 1 at a time.
- A change of `soloSeco` or `temperaturaAlta` during an irrigation phase is ignored. After returning to OCIOSO, a still-dry soil starts a new phase on the next cycle.

## Timing
- Outputs are registered, decoded from the next state, and update on the same edge as `estado`.
- Sensor edge to output change: 3 clock cycles (2 synchronizer cycles + 1 FSM edge).
- Phase length: exactly DURACAO `tick`s after entry, so true duration is DURACAO s minus the sub-second phase offset of the free-running prescaler (0..1 s).
- `umSegundo` period: 2*MEIO_PERIODO cycles. First rising edge occurs MEIO_PERIODO cycles after reset release.
- Reset asserted mid-phase: outputs drop to 0 immediately (asynchronously), not at the next clock edge.

## Test plan
Use MEIO_PERIODO=2, DURACAO_ASPERSAO=3, DURACAO_GOTEJAMENTO=2, TEMPO_ENCHER=4 for all scenarios.
- Reset, then idle: `umSegundo` toggles every 2 cycles (period 4). All other outputs 0, `estado`=0.
- `habilita`=1, `soloSeco`=1, others 0 -> `aspersao`=1 and `estado`=1 three cycles later. Returns to 0 on the 3rd subsequent `tick`, then immediately re-enters ASPERSAO (soil still dry).
- `temperaturaAlta`=1, `soloSeco`=1 -> `gotejamento`=1 for 2 ticks. Raise `nivelBaixo` mid-phase -> `gotejamento`=0 and `valvulaEntrada`=1 within 3 cycles. Raise `nivelCheio` -> back to OCIOSO.
- ENCHENDO with `nivelCheio` held 0 -> `alarme`=1 and `estado`=4 on the 4th `tick`. Stays 4 until `habilita`=0, then 0 three cycles later.
- `nivelBaixo`=`nivelCheio`=1 during ASPERSAO -> ERRO. `aspersao` and `alarme` are never high in the same cycle.
- Assert `reset`=0 mid-ASPERSAO, between clock edges -> all outputs 0 immediately. After release, `umSegundo` restarts from 0.

Source files
------------

// File: rtl/controlador_irrigacao.sv
// Irrigation mode controller: 1 s prescaler, sensor synchronizers and a five-state
// FSM that selects sprinkler, drip, tank refill or alarm for the downstream timer.
module controlador_irrigacao #(
  parameter int MEIO_PERIODO        = 25_000_000,
  parameter int DURACAO_ASPERSAO    = 3060,
  parameter int DURACAO_GOTEJAMENTO = 180,
  parameter int TEMPO_ENCHER        = 600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       soloSeco,
  input  logic       temperaturaAlta,
  input  logic       nivelBaixo,
  input  logic       nivelCheio,
  output logic       umSegundo,
  output logic       aspersao,
  output logic       gotejamento,
  output logic       valvulaEntrada,
  output logic       alarme,
  output logic [2:0] estado
);

  localparam int PW = (MEIO_PERIODO > 1) ? $clog2(MEIO_PERIODO) : 1;
  localparam logic [PW-1:0] L_PRESC_FIM = PW'(MEIO_PERIODO - 1);
  localparam logic [15:0]   L_ASP_FIM   = 16'(DURACAO_ASPERSAO - 1);
  localparam logic [15:0]   L_GOT_FIM   = 16'(DURACAO_GOTEJAMENTO - 1);
  localparam logic [15:0]   L_ENC_FIM   = 16'(TEMPO_ENCHER - 1);

  typedef enum logic [2:0] {
    S_OCIOSO      = 3'd0,
    S_ASPERSAO    = 3'd1,
    S_GOTEJAMENTO = 3'd2,
    S_ENCHENDO    = 3'd3,
    S_ERRO        = 3'd4
  } estado_t;

  logic [4:0]    w_sensores;
  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;
  logic          w_hab, w_seco, w_temp, w_baixo, w_cheio;
  logic [PW-1:0] r_presc;
  logic          r_um;
  logic          w_tick;
  logic [15:0]   r_seg;
  estado_t       r_estado;
  estado_t       w_next;
  logic          r_asp, r_got, r_val, r_alm;

  assign w_sensores = {habilita, soloSeco, temperaturaAlta, nivelBaixo, nivelCheio};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_sensores;
      r_sync2 <= r_sync1;
    end
  end

  assign {w_hab, w_seco, w_temp, w_baixo, w_cheio} = r_sync2;

  // Free-running half-period counter; tick marks the rising edge of umSegundo.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_um    <= 1'b0;
    end else if (r_presc == L_PRESC_FIM) begin
      r_presc <= '0;
      r_um    <= ~r_um;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = (r_presc == L_PRESC_FIM) && !r_um;

  always_comb begin
    w_next = r_estado;
    if (!w_hab) begin
      w_next = S_OCIOSO;
    end else if (w_baixo && w_cheio && (r_estado != S_ERRO)) begin
      w_next = S_ERRO;
    end else begin
      case (r_estado)
        S_OCIOSO: begin
          if (w_seco) begin
            if (w_baixo)     w_next = S_ENCHENDO;
            else if (w_temp) w_next = S_GOTEJAMENTO;
            else             w_next = S_ASPERSAO;
          end
        end
        S_ASPERSAO: begin
          if (w_baixo)                         w_next = S_ENCHENDO;
          else if (w_tick && r_seg == L_ASP_FIM) w_next = S_OCIOSO;
        end
        S_GOTEJAMENTO: begin
          if (w_baixo)                         w_next = S_ENCHENDO;
          else if (w_tick && r_seg == L_GOT_FIM) w_next = S_OCIOSO;
        end
        // A full tank in the same cycle as the timeout still counts as success.
        S_ENCHENDO: begin
          if (w_cheio)                         w_next = S_OCIOSO;
          else if (w_tick && r_seg == L_ENC_FIM) w_next = S_ERRO;
        end
        S_ERRO:  w_next = S_ERRO;
        default: w_next = S_OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= S_OCIOSO;
      r_seg    <= '0;
      r_asp    <= 1'b0;
      r_got    <= 1'b0;
      r_val    <= 1'b0;
      r_alm    <= 1'b0;
    end else begin
      r_estado <= w_next;
      if (w_next != r_estado)
        r_seg <= '0;
      else if (w_tick && (r_seg != 16'hFFFF))
        r_seg <= r_seg + 16'd1;
      r_asp <= (w_next == S_ASPERSAO);
      r_got <= (w_next == S_GOTEJAMENTO);
      r_val <= (w_next == S_ENCHENDO);
      r_alm <= (w_next == S_ERRO);
    end
  end

  assign umSegundo      = r_um;
  assign aspersao       = r_asp;
  assign gotejamento    = r_got;
  assign valvulaEntrada = r_val;
  assign alarme         = r_alm;
  assign estado         = r_estado;

endmodule
